// File: rtl/uart_pkg.sv
// Shared types and defaults for the oversampling UART receiver.
package uart_pkg;

    localparam int DEF_DBIT    = 8;
    localparam int DEF_OVS     = 16;
    localparam int DEF_SB_TICK = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a
// selectable reset level so idle-high lines stay quiet out of reset.
module sync_2ff #(
    parameter int   W       = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_d, meta_q;
    logic [W-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= {W{RST_VAL}};
            sync_q <= {W{RST_VAL}};
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling 8N1-style UART receiver driven by an s_tick strobe.
// Define UART_RX_PARITY_EN to add a parity bit and parity_err output.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int OVS     = DEF_OVS,
    parameter int SB_TICK = DEF_SB_TICK
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    localparam int CMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW   = clog2(CMAX);
    localparam int NW   = clog2(DBIT);

    localparam logic [SW-1:0] HALF_END = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] BIT_END  = SW'(OVS - 1);
    localparam logic [SW-1:0] STOP_END = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] LAST_BIT = NW'(DBIT - 1);

    logic rx_s;

    sync_2ff #(
        .W       (1),
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    state_e            state_d, state_q;
    logic [SW-1:0]     s_cnt_d, s_cnt_q;
    logic [NW-1:0]     n_cnt_d, n_cnt_q;
    logic [DBIT-1:0]   sh_d, sh_q;
    logic [DBIT-1:0]   dout_d, dout_q;
    logic              done_d, done_q;
    logic              ferr_d, ferr_q;
`ifdef UART_RX_PARITY_EN
    logic              par_d, par_q;
    logic              perr_d, perr_q;
`endif

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Leaves on the level itself, not on a tick.
                if (!rx_s) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == HALF_END) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_END) begin
                        sh_d    = {rx_s, sh_q[DBIT-1:1]};
                        s_cnt_d = '0;
                        if (n_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_END) begin
                        par_d   = rx_s;
                        s_cnt_d = '0;
                        state_d = STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == STOP_END) begin
                        dout_d  = sh_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (^sh_q) ^ par_q ^ PARITY_ODD;
`endif
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Scoreboard bench for uart_rx_ovs: s_tick every 4 clk, OVS=16.
// Define UART_RX_PARITY_EN to exercise the parity path as well.
module tb_uart_rx_ovs;

    typedef struct {
        logic [7:0] dout;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       s_tick;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_cyc = 0;
    int   gap      = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];

    uart_rx_ovs #(
        .DBIT    (8),
        .OVS     (16),
        .SB_TICK (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic fe,
                            input logic pe);
        exp_t e;
        e.dout = d;
        e.ferr = fe;
        e.perr = pe;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic v, input int ticks);
        rx = v;
        repeat (ticks * 4) @(negedge clk);
    endtask

    // par_flip=0 sends the correct even-parity bit when parity is built in.
    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input int stop_ticks, input logic par_flip);
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(d[i], 16);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ par_flip, 16);
`endif
        hold(stop_v, stop_ticks);
        rx = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rx_done_tick) begin
            done_cnt = done_cnt + 1;
            gap      = cyc - last_cyc;
            last_cyc = cyc;
            chk("done_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dout", {24'd0, dout}, {24'd0, e.dout});
                chk("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
`ifdef UART_RX_PARITY_EN
                chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
`endif
            end
        end
    end

    initial begin
        int n0;
        logic [7:0] v5a;
        v5a = 8'h5A;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_done", {31'd0, rx_done_tick}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef UART_RX_PARITY_EN
        chk("rst_perr", {31'd0, parity_err}, 32'd0);
`endif
        rst = 1'b0;
        hold(1'b1, 32);

        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 16, 1'b0);
        hold(1'b1, 32);

        n0 = done_cnt;
        hold(1'b0, 5);
        hold(1'b1, 32);
        chk("glitch_no_done", done_cnt, n0);
        chk("glitch_busy", {31'd0, busy}, 32'd0);
        chk("glitch_dout", {24'd0, dout}, 32'hA5);

        n0 = done_cnt;
        push_exp(8'h00, 1'b0, 1'b0);
        push_exp(8'hFF, 1'b0, 1'b0);
        send_frame(8'h00, 1'b1, 16, 1'b0);
        send_frame(8'hFF, 1'b1, 16, 1'b0);
        hold(1'b1, 32);
        chk("b2b_count", done_cnt - n0, 32'd2);
`ifdef UART_RX_PARITY_EN
        chk("b2b_gap", gap, 32'd704);
`else
        chk("b2b_gap", gap, 32'd640);
`endif

        push_exp(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 10, 1'b0);
        hold(1'b1, 48);
        push_exp(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 16, 1'b0);
        hold(1'b1, 32);

        n0 = done_cnt;
        hold(1'b0, 16);
        for (int i = 0; i < 4; i++) hold(v5a[i], 16);
        hold(v5a[4], 8);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_dout", {24'd0, dout}, 32'd0);
        chk("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, rx_done_tick}, 32'd0);
        rst = 1'b0;
        hold(1'b1, 32);
        chk("mid_rst_no_done", done_cnt, n0);
        push_exp(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 16, 1'b0);
        hold(1'b1, 32);

`ifdef UART_RX_PARITY_EN
        push_exp(8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 16, 1'b0);
        hold(1'b1, 32);
        push_exp(8'h07, 1'b0, 1'b1);
        send_frame(8'h07, 1'b1, 16, 1'b1);
        hold(1'b1, 32);
`endif

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
